// File: rtl/minority_pkg.sv
// Shared constants, FSM state type and the round-robin index helper
// for the 3-requester minority arbiter.
package minority_pkg;
  localparam int N_REQ = 3;
  localparam int ID_W  = 2;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;

  // Requester index successor, wrapping 2 -> 0.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/minority_bit.sv
// One-bit minority vote: output is 1 when at least two inputs are 0.
module minority_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic y_o
);
  assign y_o = (~a_i & ~b_i) | (~b_i & ~c_i) | (~a_i & ~c_i);
endmodule

// File: rtl/minority_arbiter.sv
// Round-robin arbiter over 3 requesters; the granted operands are reduced by a
// bitwise minority vote and returned with the owner id. One request in flight.
module minority_arbiter
  import minority_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic [N_REQ*WIDTH-1:0]   req_c,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_y,
  output logic [ID_W-1:0]          rsp_id,
  output logic [N_REQ*CNT_W-1:0]   grant_cnt
);

  state_e                       state_q;
  logic [ID_W-1:0]              ptr_q, id_q, rsp_id_q;
  logic [WIDTH-1:0]             a_q, b_q, c_q, rsp_y_q, y_w;
  logic                         rsp_valid_q;
  logic [N_REQ-1:0][CNT_W-1:0]  cnt_q;

  logic [N_REQ-1:0]             grant;
  logic [ID_W-1:0]              grant_id, idx;

  // Search ptr, ptr+1, ptr+2; the grant only exists in IDLE and out of reset.
  always_comb begin
    grant    = '0;
    grant_id = ptr_q;
    idx      = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant == '0 && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
      idx = next_id(idx);
    end
    if (!rst_n || state_q != IDLE) grant = '0;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    minority_bit u_bit (
      .a_i (a_q[g]),
      .b_i (b_q[g]),
      .c_i (c_q[g]),
      .y_o (y_w[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_id_q    <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant != '0) begin
          a_q     <= req_a[grant_id*WIDTH +: WIDTH];
          b_q     <= req_b[grant_id*WIDTH +: WIDTH];
          c_q     <= req_c[grant_id*WIDTH +: WIDTH];
          id_q    <= grant_id;
          ptr_q   <= next_id(grant_id);
          // Counters stick at all-ones instead of wrapping.
          if (cnt_q[grant_id] != '1) cnt_q[grant_id] <= cnt_q[grant_id] + CNT_W'(1);
          state_q <= EVAL;
        end
        EVAL: begin
          rsp_y_q     <= y_w;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_minority_arbiter.sv
// Bench for minority_arbiter: directed literal scenarios plus randomized traffic,
// all checked every cycle against a cycle-level behavioural model.
module tb_minority_arbiter;
  localparam int W  = 8;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [2:0]     req_valid = '0;
  logic [2:0]     req_ready;
  logic [3*W-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [W-1:0]   rsp_y;
  logic [1:0]     rsp_id;
  logic [3*CW-1:0] grant_cnt;

  int checks = 0;
  int errors = 0;

  minority_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per bit: count the zero votes, result is 1 when zeros are the majority.
  function automatic logic [W-1:0] minority(input logic [W-1:0] a, b, c);
    logic [W-1:0] y;
    y = '0;
    for (int k = 0; k < W; k++) begin
      int z;
      z = 0;
      if (!a[k]) z++;
      if (!b[k]) z++;
      if (!c[k]) z++;
      y[k] = (z >= 2);
    end
    return y;
  endfunction

  // Model: m_age = -1 when free, else cycles since the acceptance cycle (2 = response up).
  int           m_age = -1;
  int           m_ptr = 0;
  int           m_cnt [3];
  int           m_id  = 0;
  logic [W-1:0] m_y   = '0;
  bit           m_on  = 1'b0;

  always @(negedge clk) begin
    logic [2:0]      er;
    logic [3*CW-1:0] ecnt;
    int              gi;
    er = '0;
    gi = -1;
    if (rst_n && m_age < 0)
      for (int k = 0; k < 3; k++) begin
        int j;
        j = (m_ptr + k) % 3;
        if (gi < 0 && req_valid[j]) begin
          gi    = j;
          er[j] = 1'b1;
        end
      end
    if (m_on) begin
      for (int i = 0; i < 3; i++) ecnt[i*CW +: CW] = CW'(m_cnt[i]);
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_age == 2));
      chk("grant_cnt", 32'(grant_cnt), 32'(ecnt));
      if (m_age == 2) begin
        chk("rsp_y", 32'(rsp_y), 32'(m_y));
        chk("rsp_id", 32'(rsp_id), m_id);
      end
    end
    if (!rst_n) begin
      m_on  = 1'b1;
      m_age = -1;
      m_ptr = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else if (m_age < 0) begin
      if (gi >= 0) begin
        m_age = 1;
        m_ptr = (gi + 1) % 3;
        m_id  = gi;
        if (m_cnt[gi] < (1 << CW) - 1) m_cnt[gi]++;
        m_y   = minority(req_a[gi*W +: W], req_b[gi*W +: W], req_c[gi*W +: W]);
      end
    end else if (m_age < 2) begin
      m_age++;
    end else if (rsp_ready) begin
      m_age = -1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, b, c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
  endtask

  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: rsp_valid timeout, got 0 expected 1", nm);
    end
  endtask

  // One lone request from requester i, checking the 2-cycle latency literally.
  task automatic single(input int i, input logic [W-1:0] a, b, c, input logic [W-1:0] exp,
                        input string nm);
    logic [2:0] oh;
    oh = 3'(1 << i);
    set_ops(i, a, b, c);
    req_valid = oh;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(req_ready), 32'(oh));
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk({nm, "_eval_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_y"}, 32'(rsp_y), 32'(exp));
    chk({nm, "_id"}, 32'(rsp_id), i);
    cyc();
  endtask

  initial begin
    int           seq [4];
    logic [W-1:0] y0;
    logic [1:0]   id0;

    rst_n = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_y", 32'(rsp_y), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_cnt", 32'(grant_cnt), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    cyc();
    rst_n = 1'b1;

    single(0, 8'hF0, 8'hCC, 8'hAA, 8'h17, "basic");
    single(1, 8'h00, 8'h00, 8'h00, 8'hFF, "zeros");
    single(2, 8'hFF, 8'hFF, 8'hFF, 8'h00, "ones");

    // Fairness with all three requesting continuously.
    do_reset();
    set_ops(0, 8'h12, 8'h34, 8'h56);
    set_ops(1, 8'h9A, 8'hBC, 8'hDE);
    set_ops(2, 8'h0F, 8'hF0, 8'h3C);
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_rsp("fair");
      seq[r] = int'(rsp_id);
      if (r == 2) chk("fair_cnt", 32'(grant_cnt), 32'(6'b010101));
      cyc();
    end
    req_valid = '0;
    chk("fair_id0", seq[0], 0);
    chk("fair_id1", seq[1], 1);
    chk("fair_id2", seq[2], 2);
    chk("fair_id3", seq[3], 0);
    cyc();

    // Backpressure: five stalled RESP cycles while everyone keeps requesting.
    do_reset();
    set_ops(1, 8'h0F, 8'h33, 8'h55);
    req_valid = 3'b010;
    rsp_ready = 1'b0;
    @(negedge clk);
    cyc();
    req_valid = 3'b111;
    wait_rsp("bp");
    y0  = rsp_y;
    id0 = rsp_id;
    chk("bp_y", 32'(y0), 32'(8'hE8));
    chk("bp_id", 32'(id0), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_y", 32'(rsp_y), 32'(y0));
      chk("bp_hold_id", 32'(rsp_id), 32'(id0));
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    cyc();
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("bp_release", 32'(rsp_valid), 32'd1);
    cyc();
    @(negedge clk);
    chk("bp_single", 32'(rsp_valid), 32'd0);
    cyc();

    // Reset while a response is waiting.
    set_ops(0, 8'hA5, 8'h5A, 8'hFF);
    req_valid = 3'b001;
    rsp_ready = 1'b0;
    @(negedge clk);
    cyc();
    req_valid = '0;
    wait_rsp("rstmid");
    cyc();
    rst_n     = 1'b0;
    req_valid = 3'b111;
    cyc();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_cnt", 32'(grant_cnt), 32'd0);
    chk("rstmid_ready", 32'(req_ready), 32'(3'b001));
    cyc();
    req_valid = '0;
    wait_rsp("rstmid2");
    chk("rstmid_id", 32'(rsp_id), 32'd0);
    cyc();

    // Counter saturation on requester 2.
    do_reset();
    repeat (5) single(2, 8'h00, 8'h00, 8'h00, 8'hFF, "sat");
    chk("sat_cnt", 32'(grant_cnt), 32'(6'b110000));

    // Randomized traffic, including occasional resets.
    repeat (600) begin
      req_valid = 3'($urandom);
      req_a     = 24'($urandom);
      req_b     = 24'($urandom);
      req_c     = 24'($urandom);
      rsp_ready = ($urandom_range(3) != 0);
      rst_n     = ($urandom_range(60) != 0);
      cyc();
    end
    rst_n = 1'b1;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
